// File: rtl/topk_tracker.sv
// topk_tracker: keeps the K largest unsigned samples seen since reset/clear,
// sorted descending (rank 0 = largest). Entries that fall off rank K-1 are
// reported on evict_valid/evict_data.
// Optional feature macro: TOPK_UNIQUE_EN (drop samples equal to an occupied
// entry, so the table holds the K largest distinct values).
//
// Handshake: din is consumed in every cycle where din_valid is high and clear
// is low; there is no ready, the tracker accepts one sample per clock.
module topk_tracker #(
  parameter int DATA_WIDTH = 32,
  parameter int K          = 4
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         clear,
  input  logic                         din_valid,
  input  logic [DATA_WIDTH-1:0]        din,
  output logic [K*DATA_WIDTH-1:0]      dout,
  output logic [$clog2(K+1)-1:0]       count,
  output logic [DATA_WIDTH-1:0]        kth,
  output logic                         evict_valid,
  output logic [DATA_WIDTH-1:0]        evict_data
);

  localparam int CW = $clog2(K + 1);
  localparam int PW = $clog2(K);

  generate
    if (K < 2 || K > 16) begin : g_bad_k
      $error("topk_tracker: K must be in the range 2..16");
    end
  endgenerate

  // Entries are kept at 0 whenever unoccupied, so the outputs can be driven
  // straight from the entry flops and empty ranks naturally read 0.
  logic [DATA_WIDTH-1:0] r_e [K];
  logic [CW-1:0]         r_count;
  logic                  r_evict_valid;
  logic [DATA_WIDTH-1:0] r_evict_data;

  logic [K-1:0]  w_occ;
  logic [K-1:0]  w_ge;
  logic [PW-1:0] w_pos;
  logic          w_hit;
  logic          w_dup;
  logic          w_full;
  logic          w_insert;

  // Per-rank occupancy and "sample belongs at or above this rank" compare.
  always_comb begin
    w_occ = '0;
    w_ge  = '0;
    for (int i = 0; i < K; i++) begin
      w_occ[i] = (CW'(i) < r_count);
      w_ge[i]  = !w_occ[i] || (din >= r_e[i]);
    end
  end

  // Priority encode: lowest rank whose compare fires is the insert position.
  always_comb begin
    w_pos = '0;
    w_hit = 1'b0;
    for (int i = K - 1; i >= 0; i--) begin
      if (w_ge[i]) begin
        w_pos = PW'(i);
        w_hit = 1'b1;
      end
    end
  end

`ifdef TOPK_UNIQUE_EN
  // Equality against any occupied entry suppresses the insert.
  always_comb begin
    w_dup = 1'b0;
    for (int i = 0; i < K; i++) begin
      if (w_occ[i] && (din == r_e[i])) w_dup = 1'b1;
    end
  end
`else
  assign w_dup = 1'b0;
`endif

  assign w_full   = (r_count == CW'(K));
  assign w_insert = din_valid && w_hit && !w_dup;

  // Table update: insert at w_pos, shift lower ranks down, report the drop-out.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < K; i++) r_e[i] <= '0;
      r_count       <= '0;
      r_evict_valid <= 1'b0;
      r_evict_data  <= '0;
    end else if (clear) begin
      for (int i = 0; i < K; i++) r_e[i] <= '0;
      r_count       <= '0;
      r_evict_valid <= 1'b0;
      r_evict_data  <= '0;
    end else begin
      r_evict_valid <= 1'b0;
      if (w_insert) begin
        if (w_pos == '0) r_e[0] <= din;
        for (int i = 1; i < K; i++) begin
          if (PW'(i) == w_pos) begin
            r_e[i] <= din;
          end else if (PW'(i) > w_pos) begin
            r_e[i] <= r_e[i-1];
          end
        end
        if (w_full) begin
          r_evict_valid <= 1'b1;
          r_evict_data  <= r_e[K-1];
        end else begin
          r_count <= r_count + 1'b1;
        end
      end
    end
  end

  genvar r;
  generate
    for (r = 0; r < K; r++) begin : g_dout
      assign dout[r*DATA_WIDTH +: DATA_WIDTH] = r_e[r];
    end
  endgenerate

  assign count       = r_count;
  assign kth         = r_e[K-1];
  assign evict_valid = r_evict_valid;
  assign evict_data  = r_evict_data;

endmodule

// File: tb/tb_topk_tracker.sv
// Bench for topk_tracker (DATA_WIDTH=8, K=4). A sorted-queue model of the
// top-K table is compared with the DUT on every falling edge; directed
// scenarios add literal expectations. Honors TOPK_UNIQUE_EN if defined.
module tb_topk_tracker;
  localparam int DW = 8;
  localparam int K  = 4;
  localparam int CW = $clog2(K + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic              clear = 1'b0;
  logic              din_valid = 1'b0;
  logic [DW-1:0]     din = '0;
  logic [K*DW-1:0]   dout;
  logic [CW-1:0]     count;
  logic [DW-1:0]     kth;
  logic              evict_valid;
  logic [DW-1:0]     evict_data;

  topk_tracker #(.DATA_WIDTH(DW), .K(K)) dut (
    .clk(clk), .resetn(resetn), .clear(clear), .din_valid(din_valid),
    .din(din), .dout(dout), .count(count), .kth(kth),
    .evict_valid(evict_valid), .evict_data(evict_data)
  );

  int checks = 0;
  int failures = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h @%0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Table is a queue kept in descending order; its length is the count.
  logic [DW-1:0] exp_q[$];
  logic          m_ev  = 1'b0;
  logic [DW-1:0] m_evd = '0;

  task automatic model_insert(input logic [DW-1:0] v);
    int pos;
    pos = exp_q.size();
    for (int j = exp_q.size() - 1; j >= 0; j--)
      if (v >= exp_q[j]) pos = j;
    exp_q.insert(pos, v);
  endtask

  always @(posedge clk or negedge resetn) begin
    if (!resetn || clear) begin
      exp_q.delete();
      m_ev  = 1'b0;
      m_evd = '0;
    end else begin
      logic dup;
      m_ev = 1'b0;
      dup  = 1'b0;
      if (din_valid) begin
`ifdef TOPK_UNIQUE_EN
        foreach (exp_q[j]) if (exp_q[j] == din) dup = 1'b1;
`endif
        if (!dup) begin
          if (exp_q.size() < K) begin
            model_insert(din);
          end else if (din >= exp_q[K-1]) begin
            m_ev  = 1'b1;
            m_evd = exp_q[K-1];
            void'(exp_q.pop_back());
            model_insert(din);
          end
        end
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      logic [K*DW-1:0] e_dout;
      logic [DW-1:0]   e_kth;
      e_dout = '0;
      foreach (exp_q[j]) e_dout[j*DW +: DW] = exp_q[j];
      e_kth = (exp_q.size() == K) ? exp_q[K-1] : '0;
      chk("sb_dout", 64'(dout), 64'(e_dout));
      chk("sb_count", 64'(count), 64'(exp_q.size()));
      chk("sb_kth", 64'(kth), 64'(e_kth));
      chk("sb_evict_valid", 64'(evict_valid), 64'(m_ev));
      chk("sb_evict_data", 64'(evict_data), 64'(m_evd));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic v, input logic [DW-1:0] d);
    din_valid = v;
    din       = d;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  function automatic logic [K*DW-1:0] pack4(input logic [DW-1:0] r0, r1, r2, r3);
    return {r3, r2, r1, r0};
  endfunction

  logic [DW-1:0] burst_a [8] = '{8'd10, 8'd40, 8'd20, 8'd30, 8'd50, 8'd5, 8'd60, 8'd15};
  logic [DW-1:0] mix_v [12] = '{8'd100, 8'd3, 8'd100, 8'd250, 8'd7, 8'd100,
                                8'd99, 8'd251, 8'd0, 8'd255, 8'd100, 8'd101};

  // ---------------- directed scenarios ----------------
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_dout", 64'(dout), 64'd0);
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_evict_valid", 64'(evict_valid), 64'd0);
    resetn = 1'b1;
    chk_en = 1'b1;

    // 1: fill
    send(1, 8'd5); send(1, 8'd9); send(1, 8'd2); send(1, 8'd7);
    chk("fill_dout", 64'(dout), 64'(pack4(8'd9, 8'd7, 8'd5, 8'd2)));
    chk("fill_count", 64'(count), 64'd4);
    chk("fill_kth", 64'(kth), 64'd2);
    chk("fill_no_evict", 64'(evict_valid), 64'd0);

    // 2: eviction then rejection
    send(1, 8'd8);
    chk("evict_dout", 64'(dout), 64'(pack4(8'd9, 8'd8, 8'd7, 8'd5)));
    chk("evict_valid", 64'(evict_valid), 64'd1);
    chk("evict_data", 64'(evict_data), 64'd2);
    send(1, 8'd1);
    chk("reject_dout", 64'(dout), 64'(pack4(8'd9, 8'd8, 8'd7, 8'd5)));
    chk("reject_evict_valid", 64'(evict_valid), 64'd0);
    chk("reject_evict_hold", 64'(evict_data), 64'd2);

    // 4: clear beats a valid sample
    clear = 1'b1; din_valid = 1'b1; din = 8'd200;
    @(posedge clk);
    #1;
    clear = 1'b0; din_valid = 1'b0;
    chk("clear_dout", 64'(dout), 64'd0);
    chk("clear_count", 64'(count), 64'd0);
    chk("clear_evict_valid", 64'(evict_valid), 64'd0);

    // 3: duplicates
    send(1, 8'd6); send(1, 8'd6); send(1, 8'd6);
`ifdef TOPK_UNIQUE_EN
    chk("dup_dout", 64'(dout), 64'(pack4(8'd6, 8'd0, 8'd0, 8'd0)));
    chk("dup_count", 64'(count), 64'd1);
`else
    chk("dup_dout", 64'(dout), 64'(pack4(8'd6, 8'd6, 8'd6, 8'd0)));
    chk("dup_count", 64'(count), 64'd3);
`endif
    chk("dup_kth", 64'(kth), 64'd0);

    // 5: async reset in the middle of a burst
    do_clear();
    for (int i = 0; i < 4; i++) send(1, burst_a[i]);
    din_valid = 1'b1;
    din = burst_a[4];
    #2;
    resetn = 1'b0;
    #1;
    chk("async_rst_dout", 64'(dout), 64'd0);
    chk("async_rst_count", 64'(count), 64'd0);
    chk("async_rst_evict_valid", 64'(evict_valid), 64'd0);
    for (int i = 5; i < 8; i++) begin
      din = burst_a[i];
      @(posedge clk);
    end
    #1;
    din_valid = 1'b0;
    resetn = 1'b1;
    send(1, 8'd3);
    chk("post_rst_dout", 64'(dout), 64'(pack4(8'd3, 8'd0, 8'd0, 8'd0)));
    chk("post_rst_count", 64'(count), 64'd1);

    // 6: gaps and extremes
    do_clear();
    send(0, 8'd255); send(0, 8'd255);
    chk("gap_count", 64'(count), 64'd0);
    chk("gap_dout", 64'(dout), 64'd0);
    send(1, 8'd0); send(1, 8'd0); send(1, 8'd255); send(1, 8'd0); send(1, 8'd0);
    chk("ext_dout", 64'(dout), 64'(pack4(8'd255, 8'd0, 8'd0, 8'd0)));
`ifdef TOPK_UNIQUE_EN
    chk("ext_count", 64'(count), 64'd2);
`else
    chk("ext_count", 64'(count), 64'd4);
    chk("ext_evict_zero", 64'(evict_valid), 64'd1);
`endif

    // mixed sequence with gaps, checked by the scoreboard only
    do_clear();
    foreach (mix_v[i]) begin
      send(1, mix_v[i]);
      if (i % 3 == 2) send(0, 8'd255);
    end

    repeat (2) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/topk_tracker.md
# topk_tracker

- Streaming tracker that holds the K largest unsigned samples seen since the last reset or clear, sorted in descending order.
- Parametrised successor to the team's single "second largest" tracker: width and depth are generic, empty slots are tracked explicitly rather than by a zero sentinel, and samples are qualified by a valid strobe.
- Evicted values are reported so downstream statistics logic can account for them.
- Sits on the sample-monitor path after the input registers and before the statistics readout.

## Interface
Parameters:
- DATA_WIDTH, default 32: sample width in bits (unsigned).
- K, default 4: number of tracked ranks. Legal range is 2 to 16; elaboration fails outside this range.

Ports:
- clk, input, 1: rising-edge clock.
- resetn, input, 1: asynchronous active-low reset, synchronously deasserted upstream.
- clear, input, 1: synchronous flush of the table.
- din_valid, input, 1: qualifies din for this cycle.
- din, input, DATA_WIDTH: sample.
- dout, output, K*DATA_WIDTH: rank r occupies bits [r*DATA_WIDTH +: DATA_WIDTH]. Rank 0 is the largest. Empty ranks read 0.
- count, output, $clog2(K+1): number of occupied ranks, 0..K.
- kth, output, DATA_WIDTH: equals rank K-1 of dout; reads 0 while count < K.
- evict_valid, output, 1: one-cycle pulse; an occupied entry was pushed out of rank K-1.
- evict_data, output, DATA_WIDTH: the value that was pushed out; holds its last value when evict_valid is low.

## Operation
- State:
  - K entry registers e[0..K-1]
  - K occupancy flags, always a contiguous prefix, so occ[i] = (i < count)
  - evict registers
- Reset (resetn low):
  - all entries, count, kth, dout, evict_data set to 0
  - evict_valid set to 0
- clear high: same effect as reset, applied on the next edge. clear takes priority over din_valid, and the sample in that cycle is discarded.
- Insertion position when din_valid is high: p = the lowest i such that !occ[i] or din >= e[i]. If no such i exists, the sample is rejected and the table is unchanged.
- Insert at p:
  - e[p] <= din
  - e[i+1] <= e[i] for p <= i < K-1
  - entries above p are unchanged
  - count <= min(count+1, K)
- Ties use >=, so a new sample equal to an existing entry is placed above it. Duplicates occupy separate ranks unless the uniqueness feature is compiled in.
- Eviction: when count == K and an insertion occurs, the old e[K-1] leaves the table:
  - evict_valid <= 1
  - evict_data <= old e[K-1]
- A rejected sample is not an eviction.
- evict_valid is 0 in every cycle that has no eviction.
- All arithmetic is unsigned compare only. No wrap-around is possible because count saturates at K.

## Timing
- All outputs are registered. Registered outputs are those driven directly from flops.
- A sample accepted at edge N is visible on dout, count and kth after edge N.
- evict_valid and evict_data are visible in the same cycle as the updated table.
- Back-to-back valid samples are accepted every cycle with no stall.
- Throughput is 1 sample per clock.
- Reset asserted mid-stream takes effect asynchronously. Any sample in flight is lost.
- The first valid sample after resetn deasserts is handled normally.
- The compare and shift network is single-cycle. The critical path is K parallel comparators, then a priority encode, then the shift mux.

## Configuration
- TOPK_UNIQUE_EN defined:
  - a valid sample equal to any occupied entry is dropped
  - no insert, no eviction, count unchanged
  - the table therefore holds the K largest distinct values
- TOPK_UNIQUE_EN undefined: duplicates are inserted per the tie rule above.
- The macro also gates the equality comparators, so they are absent from the netlist when it is undefined.

## Test plan
All scenarios use DATA_WIDTH=8, K=4.

1. Reset then fill: send 5, 9, 2, 7 -> dout ranks = 9, 7, 5, 2; count = 4; kth = 2; no evict_valid pulses.
2. Eviction and rejection, continuing from scenario 1:
   - send 8 -> ranks = 9, 8, 7, 5; evict_valid = 1 with evict_data = 2
   - then send 1 -> table unchanged; evict_valid = 0
3. Duplicates, from reset: send 6, 6, 6.
   - With TOPK_UNIQUE_EN undefined -> ranks = 6, 6, 6, 0; count = 3.
   - With TOPK_UNIQUE_EN defined -> ranks = 6, 0, 0, 0; count = 1.
4. Clear wins: with the table full, drive clear = 1 and din_valid = 1 with din = 200 in the same cycle -> the next cycle shows all ranks 0, count = 0, evict_valid = 0.
5. Async reset mid-stream: assert resetn low between edges during a burst of 8 samples -> outputs go to 0 without waiting for a clock edge. After release, send 3 -> ranks = 3, 0, 0, 0; count = 1.
6. Gaps and extremes: din_valid = 0 while din = 255 -> no change. Then a valid burst of 0, 0, 255, 0, 0 -> ranks = 255, 0, 0, 0 and count = 4 without the uniqueness feature, or count = 2 with it.
